instruction_fetch_unit: RTL and testbench

//  Fetch/pre-decode stage upstream of the register file. Reads instruction words at PC,

---
 rtl/instruction_fetch_unit.sv | 216 +++++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch / pre-decode stage. Reads the instruction word at PC, requests PC+2
//   from the register file for every word read, collects optional source and
//   destination extension words, and presents one complete instruction bundle
//   to execute through a dec_valid / exec_ready handshake.
//
// Ports
//   clk, reset         system clock, asynchronous active-high reset
//   PC                 current PC from the register file
//   flush              branch taken: abandon the instruction in progress
//   mem_data           memory read data
//   exec_ready         execute accepts the bundle this cycle
//   mem_rd, mem_addr   one-cycle read strobe and word-aligned address
//   incPC              register file advances PC by 2 at the next edge
//   ir, src_ext,
//   dst_ext, fmt       instruction bundle (fmt: 00 I, 01 II, 10 jump, 11 illegal)
//   has_src_ext,
//   has_dst_ext        extension words present in the bundle
//   dec_valid          bundle valid for execute
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] PC,
  input  logic        flush,
  input  logic [15:0] mem_data,
  input  logic        exec_ready,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic        incPC,
  output logic [15:0] ir,
  output logic [15:0] src_ext,
  output logic [15:0] dst_ext,
  output logic [1:0]  fmt,
  output logic        has_src_ext,
  output logic        has_dst_ext,
  output logic        dec_valid
);

  localparam logic [2:0] FETCH_IR  = 3'd0;
  localparam logic [2:0] WAIT_IR   = 3'd1;
  localparam logic [2:0] FETCH_SRC = 3'd2;
  localparam logic [2:0] WAIT_SRC  = 3'd3;
  localparam logic [2:0] FETCH_DST = 3'd4;
  localparam logic [2:0] WAIT_DST  = 3'd5;
  localparam logic [2:0] ISSUE     = 3'd6;

  localparam logic [1:0] FMT_I   = 2'b00;
  localparam logic [1:0] FMT_II  = 2'b01;
  localparam logic [1:0] FMT_JMP = 2'b10;
  localparam logic [1:0] FMT_ILL = 2'b11;

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef struct packed {
    logic [1:0] fmt;
    logic       need_src;
    logic       need_dst;
  } dec_t;

  // Indexed/symbolic/absolute (As=01, except the R3 constant generator) and
  // immediate (As=11 on R0) are the source modes that carry an extension word.
  function automatic logic src_ext_needed(input logic [1:0] as_f, input logic [3:0] rsrc);
    return ((as_f == 2'b01) && (rsrc != 4'd3)) || ((as_f == 2'b11) && (rsrc == 4'd0));
  endfunction

  function automatic dec_t decode(input logic [15:0] w);
    dec_t d;
    d = '0;
    if (w[15:13] == 3'b001) begin
      d.fmt = FMT_JMP;
    end else if (w[15:10] == 6'b000100) begin
      d.fmt      = FMT_II;
      d.need_src = src_ext_needed(w[5:4], w[3:0]);
    end else if (w[15:12] >= 4'd4) begin
      d.fmt      = FMT_I;
      d.need_src = src_ext_needed(w[5:4], w[11:8]);
      d.need_dst = w[7];
    end else begin
      d.fmt = FMT_ILL;
    end
    return d;
  endfunction

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   ir_q, ir_d, src_q, src_d, dst_q, dst_d;
  logic [1:0]    fmt_q, fmt_d;
  logic          has_src_q, has_src_d, has_dst_q, has_dst_d;
  logic          flush_pend_q, flush_pend_d;   // flush seen while a read was outstanding
  logic          in_fetch;
  dec_t          dec;

  assign dec      = decode(mem_data);
  assign in_fetch = (state_q == FETCH_IR) || (state_q == FETCH_SRC) || (state_q == FETCH_DST);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ir_d         = ir_q;
    src_d        = src_q;
    dst_d        = dst_q;
    fmt_d        = fmt_q;
    has_src_d    = has_src_q;
    has_dst_d    = has_dst_q;
    flush_pend_d = flush_pend_q;

    case (state_q)
      FETCH_IR, FETCH_SRC, FETCH_DST: begin
        flush_pend_d = 1'b0;
        if (flush) begin
          has_src_d = 1'b0;
          has_dst_d = 1'b0;
          state_d   = FETCH_IR;
        end else begin
          cnt_d = CW'(WAIT_CYCLES);
          if (state_q == FETCH_IR) begin
            // A fresh instruction starts with no extension words.
            src_d     = '0;
            dst_d     = '0;
            has_src_d = 1'b0;
            has_dst_d = 1'b0;
          end
          state_d = state_q + 3'd1;   // FETCH_x -> WAIT_x by encoding
        end
      end

      WAIT_IR, WAIT_SRC, WAIT_DST: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          if (flush) flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = 1'b0;
          if (flush || flush_pend_q) begin
            // The read has completed; its data belongs to a dead path.
            has_src_d = 1'b0;
            has_dst_d = 1'b0;
            state_d   = FETCH_IR;
          end else if (state_q == WAIT_IR) begin
            ir_d  = mem_data;
            fmt_d = dec.fmt;
            if (dec.need_src)      state_d = FETCH_SRC;
            else if (dec.need_dst) state_d = FETCH_DST;
            else                   state_d = ISSUE;
          end else if (state_q == WAIT_SRC) begin
            src_d     = mem_data;
            has_src_d = 1'b1;
            state_d   = ((fmt_q == FMT_I) && ir_q[7]) ? FETCH_DST : ISSUE;
          end else begin
            dst_d     = mem_data;
            has_dst_d = 1'b1;
            state_d   = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (flush) begin
          // Flush voids any handshake in the same cycle.
          has_src_d = 1'b0;
          has_dst_d = 1'b0;
          state_d   = FETCH_IR;
        end else if (exec_ready) begin
          state_d = FETCH_IR;
        end
      end

      default: state_d = FETCH_IR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH_IR;
      cnt_q        <= '0;
      ir_q         <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      fmt_q        <= '0;
      has_src_q    <= 1'b0;
      has_dst_q    <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ir_q         <= ir_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      fmt_q        <= fmt_d;
      has_src_q    <= has_src_d;
      has_dst_q    <= has_dst_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Strobes are suppressed during flush (the register file loads the branch
  // target that edge) and while reset is held, so all outputs read 0 in reset.
  assign mem_rd      = in_fetch && !flush && !reset;
  assign incPC       = in_fetch && !flush && !reset;
  assign mem_addr    = mem_rd ? (PC & 16'hFFFE) : 16'h0000;
  assign dec_valid   = (state_q == ISSUE) && !flush;
  assign ir          = ir_q;
  assign src_ext     = src_q;
  assign dst_ext     = dst_q;
  assign fmt         = fmt_q;
  assign has_src_ext = has_src_q;
  assign has_dst_ext = has_dst_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Directed bench for instruction_fetch_unit. Two instances: u_dut0 with no
//   wait states and u_dut2 with two wait states (held in reset until used).
//   A small register-file/memory model serves the selected instance.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, rst2, flush, exec_ready0, exec_ready2, sel, pc_load;
  logic [15:0] pc, pc_target, mem_data;
  logic [4:0]  rd_idx;
  logic [15:0] mem [32];

  logic        mem_rd0, incPC0, has_src0, has_dst0, dec_valid0;
  logic [15:0] mem_addr0, ir0, src_ext0, dst_ext0;
  logic [1:0]  fmt0;
  logic        mem_rd2, incPC2, has_src2, has_dst2, dec_valid2;
  logic [15:0] mem_addr2, ir2, src_ext2, dst_ext2;
  logic [1:0]  fmt2;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;
  int inc_cnt = 0;
  int r0, i0, cyc;

  instruction_fetch_unit #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .PC(pc), .flush(flush), .mem_data(mem_data),
    .exec_ready(exec_ready0), .mem_rd(mem_rd0), .mem_addr(mem_addr0), .incPC(incPC0),
    .ir(ir0), .src_ext(src_ext0), .dst_ext(dst_ext0), .fmt(fmt0),
    .has_src_ext(has_src0), .has_dst_ext(has_dst0), .dec_valid(dec_valid0)
  );

  instruction_fetch_unit #(.WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(rst2), .PC(pc), .flush(flush), .mem_data(mem_data),
    .exec_ready(exec_ready2), .mem_rd(mem_rd2), .mem_addr(mem_addr2), .incPC(incPC2),
    .ir(ir2), .src_ext(src_ext2), .dst_ext(dst_ext2), .fmt(fmt2),
    .has_src_ext(has_src2), .has_dst_ext(has_dst2), .dec_valid(dec_valid2)
  );

  logic        mem_rd_s, incpc_s;
  logic [15:0] mem_addr_s;
  assign mem_rd_s   = sel ? mem_rd2   : mem_rd0;
  assign incpc_s    = sel ? incPC2    : incPC0;
  assign mem_addr_s = sel ? mem_addr2 : mem_addr0;
  assign mem_data   = mem[rd_idx];

  // Register file PC and memory read-data latch for the selected instance.
  always @(posedge clk) begin
    if (pc_load)      pc <= pc_target;
    else if (incpc_s) pc <= pc + 16'd2;
    if (mem_rd_s) begin
      rd_idx <= mem_addr_s[5:1];
      rd_cnt <= rd_cnt + 1;
    end
    if (incpc_s) inc_cnt <= inc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for dec_valid on the chosen instance; cyc = negedges taken.
  task automatic wait_valid(input bit which, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(which ? dec_valid2 : dec_valid0) && n < limit);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    mem[0]  = 16'h4405;  // 0x00 MOV R4,R5
    mem[1]  = 16'h40B2;  // 0x02 MOV #0x1234,&0x0200
    mem[2]  = 16'h1234;
    mem[3]  = 16'h0200;
    mem[4]  = 16'h3C05;  // 0x08 JMP
    mem[5]  = 16'h0000;  // 0x0A illegal
    mem[6]  = 16'h40B2;  // 0x0C flushed during its src ext
    mem[7]  = 16'h5555;
    mem[8]  = 16'h6666;
    mem[12] = 16'h4506;  // 0x18 branch target MOV R5,R6
    mem[16] = 16'h1214;  // 0x20 PUSH 2(R4)
    mem[17] = 16'h0002;
    mem[18] = 16'h4405;  // 0x24 read abandoned by reset
    mem[19] = 16'h4405;  // 0x26 restart target

    reset = 1'b1; rst2 = 1'b1; flush = 1'b0; sel = 1'b0;
    exec_ready0 = 1'b1; exec_ready2 = 1'b0; pc_load = 1'b1; pc_target = 16'h0000;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_mem_rd",    mem_rd0, 0);
    check("rst_incpc",     incPC0, 0);
    check("rst_mem_addr",  mem_addr0, 0);
    check("rst_ir",        ir0, 0);
    check("rst_ext",       {src_ext0, dst_ext0}, 0);
    check("rst_fmt",       fmt0, 0);
    check("rst_has",       {has_src0, has_dst0}, 0);
    check("rst_dec_valid", dec_valid0, 0);

    // MOV R4,R5: single word, minimum latency
    pc_load = 1'b0; reset = 1'b0; #1;
    check("mov_mem_rd", mem_rd0, 1);
    check("mov_incpc",  incPC0, 1);
    check("mov_addr",   mem_addr0, 16'h0000);
    r0 = rd_cnt; i0 = inc_cnt;
    wait_valid(1'b0, 20, cyc);
    check("mov_latency", cyc, 2);
    check("mov_ir",      ir0, 16'h4405);
    check("mov_fmt",     fmt0, 2'b00);
    check("mov_has",     {has_src0, has_dst0}, 0);
    check("mov_ext",     {src_ext0, dst_ext0}, 0);
    check("mov_reads",   rd_cnt - r0, 1);
    check("mov_incs",    inc_cnt - i0, 1);

    // MOV #0x1234,&0x0200: both extension words
    r0 = rd_cnt; i0 = inc_cnt;
    wait_valid(1'b0, 30, cyc);
    check("imm_latency", cyc, 7);
    check("imm_ir",      ir0, 16'h40B2);
    check("imm_src",     src_ext0, 16'h1234);
    check("imm_dst",     dst_ext0, 16'h0200);
    check("imm_has",     {has_src0, has_dst0}, 2'b11);
    check("imm_fmt",     fmt0, 2'b00);
    check("imm_reads",   rd_cnt - r0, 3);
    check("imm_incs",    inc_cnt - i0, 3);

    // JMP held in ISSUE while execute stalls
    @(negedge clk);
    check("jmp_addr", mem_addr0, 16'h0008);
    exec_ready0 = 1'b0;
    wait_valid(1'b0, 20, cyc);
    check("jmp_latency", cyc, 2);
    check("jmp_ir",      ir0, 16'h3C05);
    check("jmp_fmt",     fmt0, 2'b10);
    check("jmp_has",     {has_src0, has_dst0}, 0);
    check("jmp_ext_clr", {src_ext0, dst_ext0}, 0);
    r0 = rd_cnt;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("jmp_hold_valid", dec_valid0, 1);
      check("jmp_hold_ir",    ir0, 16'h3C05);
    end
    check("jmp_no_reads", rd_cnt - r0, 0);
    exec_ready0 = 1'b1;
    @(negedge clk);
    check("hs_valid_drop", dec_valid0, 0);
    check("hs_next_rd",    mem_rd0, 1);
    check("hs_next_addr",  mem_addr0, 16'h000A);

    // Illegal opcode 0x0000
    r0 = rd_cnt;
    wait_valid(1'b0, 20, cyc);
    check("ill_latency", cyc, 2);
    check("ill_ir",      ir0, 16'h0000);
    check("ill_fmt",     fmt0, 2'b11);
    check("ill_has",     {has_src0, has_dst0}, 0);
    check("ill_reads",   rd_cnt - r0, 1);

    // Flush during WAIT_SRC of the instruction at 0x0C
    repeat (4) @(negedge clk);
    check("fl_wait_rd", mem_rd0, 0);
    flush = 1'b1; pc_load = 1'b1; pc_target = 16'h0018; #1;
    check("fl_incpc", incPC0, 0);
    @(negedge clk);
    flush = 1'b0; pc_load = 1'b0; #1;
    check("fl_refetch_rd",   mem_rd0, 1);
    check("fl_refetch_addr", mem_addr0, 16'h0018);
    check("fl_has_src",      has_src0, 0);
    check("fl_src_ext",      src_ext0, 0);
    wait_valid(1'b0, 20, cyc);
    check("fl_latency", cyc, 2);
    check("fl_ir",      ir0, 16'h4506);
    check("fl_has",     {has_src0, has_dst0}, 0);

    // Flush with exec_ready in ISSUE voids the handshake; flush in FETCH_IR
    flush = 1'b1; pc_load = 1'b1; pc_target = 16'h0018; #1;
    check("flis_valid", dec_valid0, 0);
    @(negedge clk);
    check("flf_mem_rd", mem_rd0, 0);
    check("flf_incpc",  incPC0, 0);
    @(negedge clk);
    flush = 1'b0; pc_load = 1'b0; #1;
    check("flf_rd",    mem_rd0, 1);
    check("flf_incpc_after", incPC0, 1);
    check("flf_addr",  mem_addr0, 16'h0018);
    wait_valid(1'b0, 20, cyc);
    check("flf_latency", cyc, 2);
    check("flf_ir",      ir0, 16'h4506);
    exec_ready0 = 1'b0;

    // PUSH 2(R4) with two wait states
    sel = 1'b1; pc_load = 1'b1; pc_target = 16'h0020;
    @(negedge clk);
    pc_load = 1'b0; rst2 = 1'b0; #1;
    check("push_rd",   mem_rd2, 1);
    check("push_addr", mem_addr2, 16'h0020);
    r0 = rd_cnt;
    repeat (3) @(negedge clk);
    check("push_ir_not_yet", ir2, 16'h0000);
    check("push_wait_rd",    mem_rd2, 0);
    @(negedge clk);
    check("push_ir",       ir2, 16'h1214);
    check("push_src_rd",   mem_rd2, 1);
    check("push_src_addr", mem_addr2, 16'h0022);
    repeat (3) @(negedge clk);
    check("push_src_not_yet", src_ext2, 16'h0000);
    @(negedge clk);
    check("push_valid", dec_valid2, 1);
    check("push_src",   src_ext2, 16'h0002);
    check("push_fmt",   fmt2, 2'b01);
    check("push_has",   {has_src2, has_dst2}, 2'b10);
    check("push_dst",   dst_ext2, 0);
    check("push_reads", rd_cnt - r0, 2);

    // Asynchronous reset in the middle of a wait
    exec_ready2 = 1'b1;
    repeat (2) @(negedge clk);
    rst2 = 1'b1; #1;
    check("ar_ir",    ir2, 0);
    check("ar_fmt",   fmt2, 0);
    check("ar_ext",   {src_ext2, dst_ext2}, 0);
    check("ar_has",   {has_src2, has_dst2}, 0);
    check("ar_valid", dec_valid2, 0);
    check("ar_strb",  {mem_rd2, incPC2}, 0);
    check("ar_addr",  mem_addr2, 0);
    @(negedge clk);
    rst2 = 1'b0; #1;
    check("ar_restart_rd",   mem_rd2, 1);
    check("ar_restart_addr", mem_addr2, 16'h0026);
    wait_valid(1'b1, 20, cyc);
    check("ar_latency", cyc, 4);
    check("ar_ir_new",  ir2, 16'h4405);
    check("ar_fmt_new", fmt2, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
